// File: rtl/main_fsm_pkg.sv
// ============================================================================
// Module  : main_fsm_pkg
// Brief   : State, opcode and datapath-select encodings shared by main_fsm,
//           aluDeco and the datapath.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package main_fsm_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWRITE = 4'd4,
        S_MEMWB    = 4'd5,
        S_EXER     = 4'd6,
        S_EXEI     = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW    = 7'd3;
    localparam logic [6:0] OP_SW    = 7'd35;
    localparam logic [6:0] OP_RTYPE = 7'd51;
    localparam logic [6:0] OP_ITYPE = 7'd19;
    localparam logic [6:0] OP_BEQ   = 7'd99;
    localparam logic [6:0] OP_JAL   = 7'd111;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

endpackage

`default_nettype wire

// File: rtl/main_fsm_wait.sv
// ============================================================================
// Module  : main_fsm_wait
// Brief   : 4-bit wait-state counter; done flags the final cycle of a state
//           (count == LIMIT). Clear restarts the count on a state change.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module main_fsm_wait #(
    parameter int LIMIT = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    output logic done
);

    logic [3:0] r_count;

    assign done = (r_count == 4'(LIMIT));

    // Saturates at LIMIT so a state that never waits cannot wrap the count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= 4'd0;
        end else if (clear) begin
            r_count <= 4'd0;
        end else if (!done) begin
            r_count <= r_count + 4'd1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/main_fsm.sv
// ============================================================================
// Module  : main_fsm
// Brief   : Multicycle main controller with memory wait states, I-type ALU,
//           illegal-opcode pulse and retired counter. Macro MAIN_FSM_JAL_EN
//           enables the JAL path.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module main_fsm
    import main_fsm_pkg::*;
#(
    parameter int MEM_LAT = 1,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [6:0]       op,
    output logic             pcUpdate,
    output logic             branch,
    output logic             adrSrc,
    output logic             memWrite,
    output logic             irWrite,
    output logic [1:0]       resSrc,
    output logic [1:0]       aluSrcA,
    output logic [1:0]       aluSrcB,
    output logic [1:0]       aluOp,
    output logic [1:0]       inmSrc,
    output logic             regWrite,
    output logic             illegal,
    output logic             instrDone,
    output logic [CNT_W-1:0] retired
);

    state_t           r_state;
    state_t           w_next;
    logic             w_done;
    logic             w_pc, w_br, w_mw, w_ir, w_rw, w_ill, w_fin;
    logic [CNT_W-1:0] r_retired;

    main_fsm_wait #(
        .LIMIT   (MEM_LAT)
    ) u_wait (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (w_next != r_state),
        .done    (w_done)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_pc    = 1'b0;
        w_br    = 1'b0;
        w_mw    = 1'b0;
        w_ir    = 1'b0;
        w_rw    = 1'b0;
        w_ill   = 1'b0;
        w_fin   = 1'b0;
        adrSrc  = 1'b0;
        resSrc  = RES_ALUOUT;
        aluSrcA = SRCA_PC;
        aluSrcB = SRCB_RS2;
        aluOp   = ALUOP_ADD;
        case (r_state)
            S_FETCH: begin
                aluSrcB = SRCB_FOUR;
                resSrc  = RES_ALURES;
                if (w_done) begin
                    w_ir   = 1'b1;
                    w_pc   = 1'b1;
                    w_next = S_DECODE;
                end
            end
            S_DECODE: begin
                aluSrcA = SRCA_OLDPC;
                aluSrcB = SRCB_IMM;
                case (op)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_RTYPE:     w_next = S_EXER;
                    OP_ITYPE:     w_next = S_EXEI;
                    OP_BEQ:       w_next = S_BEQ;
`ifdef MAIN_FSM_JAL_EN
                    OP_JAL:       w_next = S_JAL;
`endif
                    default: begin
                        w_ill  = 1'b1;
                        w_next = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                aluSrcA = SRCA_RS1;
                aluSrcB = SRCB_IMM;
                if (op == OP_LW)      w_next = S_MEMREAD;
                else if (op == OP_SW) w_next = S_MEMWRITE;
                else                  w_next = S_FETCH;
            end
            S_MEMREAD: begin
                adrSrc = 1'b1;
                if (w_done) w_next = S_MEMWB;
            end
            S_MEMWRITE: begin
                adrSrc = 1'b1;
                if (w_done) begin
                    w_mw   = 1'b1;
                    w_fin  = 1'b1;
                    w_next = S_FETCH;
                end
            end
            S_MEMWB: begin
                resSrc = RES_DATA;
                w_rw   = 1'b1;
                w_fin  = 1'b1;
                w_next = S_FETCH;
            end
            S_EXER: begin
                aluSrcA = SRCA_RS1;
                aluSrcB = SRCB_RS2;
                aluOp   = ALUOP_FUNCT;
                w_next  = S_ALUWB;
            end
            S_EXEI: begin
                aluSrcA = SRCA_RS1;
                aluSrcB = SRCB_IMM;
                aluOp   = ALUOP_FUNCT;
                w_next  = S_ALUWB;
            end
            S_ALUWB: begin
                resSrc = RES_ALUOUT;
                w_rw   = 1'b1;
                w_fin  = 1'b1;
                w_next = S_FETCH;
            end
            S_BEQ: begin
                aluSrcA = SRCA_RS1;
                aluSrcB = SRCB_RS2;
                aluOp   = ALUOP_SUB;
                w_br    = 1'b1;
                w_fin   = 1'b1;
                w_next  = S_FETCH;
            end
`ifdef MAIN_FSM_JAL_EN
            S_JAL: begin
                aluSrcA = SRCA_OLDPC;
                aluSrcB = SRCB_FOUR;
                w_pc    = 1'b1;
                w_next  = S_ALUWB;
            end
`endif
            default: w_next = S_FETCH;
        endcase
    end

    always_comb begin
        case (op)
            OP_LW, OP_ITYPE: inmSrc = IMM_I;
            OP_SW:           inmSrc = IMM_S;
            OP_BEQ:          inmSrc = IMM_B;
`ifdef MAIN_FSM_JAL_EN
            OP_JAL:          inmSrc = IMM_J;
`endif
            default:         inmSrc = 2'bxx;
        endcase
    end

    // Strobes are masked by reset so nothing writes while reset is held.
    assign pcUpdate  = w_pc  & reset_n;
    assign branch    = w_br  & reset_n;
    assign memWrite  = w_mw  & reset_n;
    assign irWrite   = w_ir  & reset_n;
    assign regWrite  = w_rw  & reset_n;
    assign illegal   = w_ill & reset_n;
    assign instrDone = w_fin & reset_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_retired <= '0;
        end else if (w_fin) begin
            r_retired <= r_retired + CNT_W'(1);
        end
    end

    assign retired = r_retired;

endmodule

`default_nettype wire
